// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared definitions for the adder_arb16 arbiter slice.
//   - arb_state_e : controller FSM states (idle, issue, wait, done)
//   - ARB_NUM_REQ : default requester count
//   - ARB_DATA_W  : default operand/result width
//   - ARB_TIMEOUT : default WAIT-state cycle limit (ADDER_ARB_TIMEOUT_EN builds only)
package adder_arb_pkg;

   localparam int unsigned ARB_NUM_REQ = 4;
   localparam int unsigned ARB_DATA_W  = 16;
   localparam int unsigned ARB_TIMEOUT = 15;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StDone  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin pick.
// Ports:
//   req    in  4  request vector
//   last   in  2  index of the most recently served requester
//   winner out 4  one-hot winner (all zero when no request)
//   idx    out 2  winner index (equals last when no request)
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [3:0] winner,
   output logic [1:0] idx
);

   logic [1:0] cand;

   // Scan from farthest to nearest so the requester closest after last
   // overrides any earlier hit.
   always_comb begin
      winner = '0;
      idx    = last;
      cand   = last;
      for (int off = 4; off >= 1; off--) begin
         cand = last + 2'(off);
         if (req[cand]) begin
            winner       = '0;
            winner[cand] = 1'b1;
            idx          = cand;
         end
      end
   end

endmodule

// File: rtl/adder_arb16.sv
// adder_arb16: round-robin controller sharing one 16-bit add/subtract
// datapath between four requesters. Latches the winner's operands, drives
// the adder enable/ready handshake and returns a registered result with a
// one-cycle done pulse.
// Optional feature macro: ADDER_ARB_TIMEOUT_EN (WAIT-state timeout, err flag).
// Ports:
//   clk, rst_n         clock, async active-low reset
//   req, sub           per-requester request and op select (1 = A-B)
//   a_flat, b_flat     packed operands, requester i at [16i+15:16i]
//   gnt, done          one-hot grant (ISSUE..DONE) and completion pulse
//   result, c_out, err registered result, carry-out, timeout flag
//   busy               high whenever the FSM is not idle
//   add_en, add_c_in   adder enable and carry-in / subtract select
//   add_a, add_b       adder operands (B unmodified; adder inverts it)
//   add_sum, add_cout  adder result and carry-out
//   add_ready          adder result valid
module adder_arb16
   import adder_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = ARB_NUM_REQ,
   parameter int unsigned DATA_W  = ARB_DATA_W,
   parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        sub,
   input  logic [NUM_REQ*DATA_W-1:0] a_flat,
   input  logic [NUM_REQ*DATA_W-1:0] b_flat,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         result,
   output logic                      c_out,
   output logic                      err,
   output logic                      busy,
   output logic                      add_en,
   output logic                      add_c_in,
   output logic [DATA_W-1:0]         add_a,
   output logic [DATA_W-1:0]         add_b,
   input  logic [DATA_W-1:0]         add_sum,
   input  logic                      add_cout,
   input  logic                      add_ready
);

   // The arbiter and 4-bit wait counter only support this parameter set.
   if (NUM_REQ != 4 || DATA_W == 0 || TIMEOUT == 0 || TIMEOUT > 15) begin : g_bad_cfg
      $error("adder_arb16: unsupported parameter set");
   end

   arb_state_e state_q, state_d;

   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [DATA_W-1:0]  result_q, result_d;
   logic               c_out_q, c_out_d;
   logic               busy_q, busy_d;
   logic               add_en_q, add_en_d;
   logic               add_c_in_q, add_c_in_d;
   logic [DATA_W-1:0]  add_a_q, add_a_d;
   logic [DATA_W-1:0]  add_b_q, add_b_d;
   logic [1:0]         win_q, win_d;
   logic [1:0]         last_q, last_d;

   logic [3:0] pick_oh;
   logic [1:0] pick_idx;

   logic [DATA_W-1:0] a_arr [NUM_REQ];
   logic [DATA_W-1:0] b_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign a_arr[i] = a_flat[i*DATA_W +: DATA_W];
      assign b_arr[i] = b_flat[i*DATA_W +: DATA_W];
   end

   rr_arbiter4 u_rr_arbiter4 (
      .req    (req),
      .last   (last_q),
      .winner (pick_oh),
      .idx    (pick_idx)
   );

`ifdef ADDER_ARB_TIMEOUT_EN
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       err_q, err_d;
`endif

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      done_d     = '0;
      result_d   = result_q;
      c_out_d    = c_out_q;
      add_en_d   = add_en_q;
      add_c_in_d = add_c_in_q;
      add_a_d    = add_a_q;
      add_b_d    = add_b_q;
      win_d      = win_q;
      last_d     = last_q;
`ifdef ADDER_ARB_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (|req) begin
               // Operands are captured here; later input changes are ignored.
               state_d    = StIssue;
               gnt_d      = pick_oh;
               win_d      = pick_idx;
               add_a_d    = a_arr[pick_idx];
               add_b_d    = b_arr[pick_idx];
               add_c_in_d = sub[pick_idx];
               add_en_d   = 1'b1;
            end
         end
         StIssue: begin
            // add_ready may still reflect a previous op here, so it is ignored.
            state_d = StWait;
`ifdef ADDER_ARB_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end
         StWait: begin
            if (add_ready) begin
               state_d  = StDone;
               result_d = add_sum;
               c_out_d  = add_cout;
               done_d   = gnt_q;
               add_en_d = 1'b0;
`ifdef ADDER_ARB_TIMEOUT_EN
               err_d    = 1'b0;
            end else if (wait_cnt_q == 4'(TIMEOUT - 1)) begin
               state_d  = StDone;
               result_d = '0;
               c_out_d  = 1'b0;
               done_d   = gnt_q;
               add_en_d = 1'b0;
               err_d    = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
`endif
            end
         end
         StDone: begin
            state_d = StIdle;
            gnt_d   = '0;
            last_d  = win_q;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         gnt_q      <= '0;
         done_q     <= '0;
         result_q   <= '0;
         c_out_q    <= 1'b0;
         busy_q     <= 1'b0;
         add_en_q   <= 1'b0;
         add_c_in_q <= 1'b0;
         add_a_q    <= '0;
         add_b_q    <= '0;
         win_q      <= 2'd0;
         last_q     <= 2'd3;  // requester 0 wins the first arbitration
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         result_q   <= result_d;
         c_out_q    <= c_out_d;
         busy_q     <= busy_d;
         add_en_q   <= add_en_d;
         add_c_in_q <= add_c_in_d;
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         win_q      <= win_d;
         last_q     <= last_d;
      end
   end

`ifdef ADDER_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign gnt      = gnt_q;
   assign done     = done_q;
   assign result   = result_q;
   assign c_out    = c_out_q;
   assign busy     = busy_q;
   assign add_en   = add_en_q;
   assign add_c_in = add_c_in_q;
   assign add_a    = add_a_q;
   assign add_b    = add_b_q;

endmodule

// File: tb/tb_adder_arb16.sv
// tb_adder_arb16: directed self-checking bench for adder_arb16. The bench
// plays the shared adder (sum of A and B, or A + ~B + 1 when add_c_in) and
// raises add_ready a programmable number of WAIT cycles after the issue.
module tb_adder_arb16;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  sub;
   logic [63:0] a_flat;
   logic [63:0] b_flat;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic [15:0] result;
   logic        c_out;
   logic        err;
   logic        busy;
   logic        add_en;
   logic        add_c_in;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic [15:0] add_sum;
   logic        add_cout;
   logic        add_ready;

   logic [15:0] a_arr [4];
   logic [15:0] b_arr [4];
   int          ready_delay;
   int          en_cnt;
   int          n_vec;
   int          n_err;

   logic [15:0] rr_res [4];

   assign a_flat = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
   assign b_flat = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

   // Shared adder stand-in.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, (add_c_in ? ~add_b : add_b)}
                                + 17'(add_c_in);

   // en_cnt is 0 during ISSUE and 1 on the first WAIT cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) en_cnt <= 0;
      else        en_cnt <= add_en ? en_cnt + 1 : 0;
   end
   assign add_ready = add_en && (en_cnt > ready_delay);

   adder_arb16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .sub       (sub),
      .a_flat    (a_flat),
      .b_flat    (b_flat),
      .gnt       (gnt),
      .done      (done),
      .result    (result),
      .c_out     (c_out),
      .err       (err),
      .busy      (busy),
      .add_en    (add_en),
      .add_c_in  (add_c_in),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .add_ready (add_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_gnt"},      32'(gnt), 0);
      check({pfx, "_done"},     32'(done), 0);
      check({pfx, "_result"},   32'(result), 0);
      check({pfx, "_c_out"},    32'(c_out), 0);
      check({pfx, "_err"},      32'(err), 0);
      check({pfx, "_busy"},     32'(busy), 0);
      check({pfx, "_add_en"},   32'(add_en), 0);
      check({pfx, "_add_c_in"}, 32'(add_c_in), 0);
      check({pfx, "_add_a"},    32'(add_a), 0);
      check({pfx, "_add_b"},    32'(add_b), 0);
   endtask

   // Drive one request pattern and follow the winner through to done.
   task automatic do_op(input logic [3:0] mask, input int idx, input logic s,
                        input logic [15:0] a, input logic [15:0] b,
                        input int delay, input logic drop,
                        input logic [15:0] exp_r, input logic exp_c,
                        input logic exp_e, input int exp_lat);
      int         cyc;
      logic [3:0] oh;
      oh          = 4'b0001 << idx;
      a_arr[idx]  = a;
      b_arr[idx]  = b;
      sub[idx]    = s;
      ready_delay = delay;
      req         = mask;
      cyc         = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            check("issue_gnt",      32'(gnt), 32'(oh));
            check("issue_busy",     32'(busy), 1);
            check("issue_add_en",   32'(add_en), 1);
            check("issue_add_a",    32'(add_a), 32'(a));
            check("issue_add_b",    32'(add_b), 32'(b));
            check("issue_add_c_in", 32'(add_c_in), 32'(s));
            // Scramble inputs after the grant; the latched copy must win.
            a_arr[idx] = 16'hDEAD;
            b_arr[idx] = 16'hBEEF;
            sub[idx]   = ~s;
         end
         if (drop && cyc == 2) req = '0;
      end while (done == '0 && cyc < 40);
      check("done_latency", 32'(cyc), 32'(exp_lat));
      check("done_onehot",  32'(done), 32'(oh));
      check("done_gnt",     32'(gnt), 32'(oh));
      check("done_result",  32'(result), 32'(exp_r));
      check("done_c_out",   32'(c_out), 32'(exp_c));
      check("done_err",     32'(err), 32'(exp_e));
      req = '0;
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
      check("idle_busy",  32'(busy), 0);
      check("idle_gnt",   32'(gnt), 0);
   endtask

   initial begin
      int cyc;
      n_vec       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      req         = '0;
      sub         = '0;
      ready_delay = 0;
      for (int i = 0; i < 4; i++) begin
         a_arr[i] = '0;
         b_arr[i] = '0;
      end
      rr_res[0] = 16'h1001;
      rr_res[1] = 16'h2002;
      rr_res[2] = 16'h3003;
      rr_res[3] = 16'h4004;

      @(negedge clk);
      @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Basic add, subtract both ways, and an add with carry-out.
      do_op(4'b0001, 0, 1'b0, 16'h1234, 16'h1111, 0, 1'b0, 16'h2345, 1'b0, 1'b0, 3);
      do_op(4'b0010, 1, 1'b1, 16'h0005, 16'h0007, 0, 1'b0, 16'hFFFE, 1'b0, 1'b0, 3);
      do_op(4'b0010, 1, 1'b1, 16'h0007, 16'h0005, 0, 1'b0, 16'h0002, 1'b1, 1'b0, 3);
      do_op(4'b1000, 3, 1'b0, 16'hFFFF, 16'h0001, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 3);

      // Round-robin from reset with all four requesting continuously.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sub   = '0;
      for (int i = 0; i < 4; i++) begin
         a_arr[i] = 16'(16'h1000 * (i + 1));
         b_arr[i] = 16'(i + 1);
      end
      ready_delay = 0;
      req         = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (done == '0 && cyc < 20);
         check("rr_latency", 32'(cyc), 3);
         check("rr_done",    32'(done), 32'(4'b0001 << (n % 4)));
         check("rr_result",  32'(result), 32'(rr_res[n % 4]));
         if (n == 4) req = '0;
         @(negedge clk);
         check("rr_pulse",    32'(done), 0);
         check("rr_idle_gnt", 32'(gnt), 0);
      end

      // Request dropped in WAIT with a slow adder: op still completes.
      do_op(4'b0100, 2, 1'b1, 16'h8000, 16'h0001, 5, 1'b1, 16'h7FFF, 1'b1, 1'b0, 8);

      // Reset mid-WAIT: everything clears at once and no done appears.
      a_arr[3]    = 16'h0F0F;
      b_arr[3]    = 16'h0101;
      sub[3]      = 1'b0;
      ready_delay = 1000;
      req         = 4'b1000;
      @(negedge clk);
      check("inflight_gnt", 32'(gnt), 32'(4'b1000));
      @(negedge clk);
      @(negedge clk);
      check("inflight_add_en", 32'(add_en), 1);
      rst_n = 1'b0;
      #1;
      check_reset("midwait");
      req = '0;
      @(negedge clk);
      check("midwait_no_done", 32'(done), 0);
      rst_n = 1'b1;

      // Pointer restored by reset: requester 0 beats requester 3.
      do_op(4'b1001, 0, 1'b0, 16'h0001, 16'h0002, 0, 1'b0, 16'h0003, 1'b0, 1'b0, 3);
      // Last served 0, so requester 2 is next ahead of 0.
      do_op(4'b0101, 2, 1'b0, 16'h0100, 16'h0200, 0, 1'b0, 16'h0300, 1'b0, 1'b0, 3);

`ifdef ADDER_ARB_TIMEOUT_EN
      do_op(4'b0010, 1, 1'b0, 16'h1111, 16'h2222, 1000, 1'b0, 16'h0000, 1'b0, 1'b1, 17);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
